// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: OP/M-extension encodings and the mul/div sequencer states.
package riscv_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIN = 2'd2} md_state_e;

endpackage

// File: rtl/riscv_muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide on a {hi,lo} pair.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_t;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    sum   = {1'b0, hi_i} + (lo_i[0] ? {1'b0, b_i} : {(WIDTH+1){1'b0}});
    rem_t = {hi_i, lo_i[WIDTH-1]};
    ge    = (rem_t >= {1'b0, b_i});
    // partial remainder stays below the divisor, so the difference fits WIDTH bits
    diff  = rem_t[WIDTH-1:0] - b_i;
    if (is_div_i) begin
      hi_o = ge ? diff : rem_t[WIDTH-1:0];
      lo_o = {lo_i[WIDTH-2:0], ge};
    end else begin
      hi_o = sum[WIDTH:1];
      lo_o = {sum[0], lo_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: magnitudes in, BITS_PER_CYCLE steps per clock, sign fix-up in FIN.
module riscv_muldiv_unit
  import riscv_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic             Kill,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [4:0]       RdIn,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [4:0]       RdOut
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N) + 1;

  md_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic             neg_q, neg_d, negr_q, negr_d;
  logic [4:0]       rdl_q, rdl_d, rd_q, rd_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             done_q, done_d;

  logic             a_neg, b_neg, is_div, b_zero, ovf;
  logic [WIDTH-1:0] a_abs, b_abs, quo, rem, res;
  logic [2*WIDTH-1:0] prod;

  logic [BITS_PER_CYCLE:0][WIDTH-1:0] hi_c, lo_c;

  assign hi_c[0] = hi_q;
  assign lo_c[0] = lo_q;

  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div_i (op_q[2]),
      .hi_i     (hi_c[g]),
      .lo_i     (lo_c[g]),
      .b_i      (b_q),
      .hi_o     (hi_c[g+1]),
      .lo_o     (lo_c[g+1])
    );
  end

  always_comb begin
    a_neg  = ((Op == F3_MULH) || (Op == F3_MULHSU) || (Op == F3_DIV) || (Op == F3_REM))
             && SrcA[WIDTH-1];
    b_neg  = ((Op == F3_MULH) || (Op == F3_DIV) || (Op == F3_REM)) && SrcB[WIDTH-1];
    a_abs  = a_neg ? -SrcA : SrcA;
    b_abs  = b_neg ? -SrcB : SrcB;
    is_div = Op[2];
    b_zero = (SrcB == '0);
    ovf    = is_div && !Op[0] && (SrcA == {1'b1, {(WIDTH-1){1'b0}}}) && (SrcB == '1);
  end

  // Sign fix-up and result select, consumed at the FIN edge
  always_comb begin
    prod = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    quo  = neg_q ? -lo_q : lo_q;
    rem  = negr_q ? -hi_q : hi_q;
    case (op_q)
      F3_MUL:                        res = prod[WIDTH-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  res = prod[2*WIDTH-1:WIDTH];
      F3_REM, F3_REMU:               res = rem;
      default:                       res = quo;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    b_d     = b_q;
    neg_d   = neg_q;
    negr_d  = negr_q;
    rdl_d   = rdl_q;
    rd_d    = rd_q;
    res_d   = res_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (Start) begin
        op_d  = Op;
        rdl_d = RdIn;
        cnt_d = '0;
        b_d   = b_abs;
        // Fast-path results are preloaded raw, so sign correction is disabled
        if (is_div && b_zero) begin
          hi_d = SrcA; lo_d = '1; neg_d = 1'b0; negr_d = 1'b0; state_d = FIN;
        end else if (ovf) begin
          hi_d = '0; lo_d = SrcA; neg_d = 1'b0; negr_d = 1'b0; state_d = FIN;
        end else begin
          hi_d = '0; lo_d = a_abs; neg_d = a_neg ^ b_neg; negr_d = a_neg; state_d = CALC;
        end
      end
      CALC: begin
        hi_d  = hi_c[BITS_PER_CYCLE];
        lo_d  = lo_c[BITS_PER_CYCLE];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N-1)) state_d = FIN;
      end
      FIN: begin
        res_d   = res;
        rd_d    = rdl_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (Kill) begin
      state_d = IDLE;
      done_d  = 1'b0;
      res_d   = res_q;
      rd_d    = rd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      neg_q   <= 1'b0;
      negr_q  <= 1'b0;
      rdl_q   <= '0;
      rd_q    <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      b_q     <= b_d;
      neg_q   <= neg_d;
      negr_q  <= negr_d;
      rdl_q   <= rdl_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  assign Busy   = (state_q != IDLE);
  assign Done   = done_q;
  assign Result = res_q;
  assign RdOut  = rd_q;

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Bench: radix-2 and radix-16 units side by side against a plain-arithmetic RV32M model.
module tb_riscv_muldiv_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, start, kill1, kill4;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic [4:0]  rd;
  logic        busy1, done1, busy4, done4;
  logic [31:0] res1, res4;
  logic [4:0]  rdo1, rdo4;
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  riscv_muldiv_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .reset(rst_n), .Start(start), .Kill(kill1), .Op(op), .SrcA(a), .SrcB(b),
    .RdIn(rd), .Busy(busy1), .Done(done1), .Result(res1), .RdOut(rdo1));

  riscv_muldiv_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .reset(rst_n), .Start(start), .Kill(kill4), .Op(op), .SrcA(a), .SrcB(b),
    .RdIn(rd), .Busy(busy4), .Done(done4), .Result(res4), .RdOut(rdo4));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] x,
                                         input logic [31:0] y);
    longint sx, sy, ux, uy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    p  = '0;
    case (f)
      F3_MUL:    begin p = ux * uy; return p[31:0]; end
      F3_MULH:   begin p = sx * sy; return p[63:32]; end
      F3_MULHSU: begin p = sx * uy; return p[63:32]; end
      F3_MULHU:  begin p = ux * uy; return p[63:32]; end
      F3_DIV: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
        p = sx / sy; return p[31:0];
      end
      F3_DIVU: begin
        if (y == 0) return 32'hFFFF_FFFF;
        return x / y;
      end
      F3_REM: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
        p = sx % sy; return p[31:0];
      end
      default: begin
        if (y == 0) return x;
        return x % y;
      end
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    return f[2] && (y == 0 || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
  endfunction

  task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] r);
    int lat1, lat4, bc1, bc4, e1, e4;
    logic [31:0] g1, g4, e;
    logic [4:0]  gr1, gr4;
    lat1 = -1; lat4 = -1; bc1 = 0; bc4 = 0;
    g1 = '0; g4 = '0; gr1 = '0; gr4 = '0;
    @(negedge clk);
    op = f; a = x; b = y; rd = r; start = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 60; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy1) bc1++;
      if (busy4) bc4++;
      if (lat4 >= 0 && j == lat4 + 1) chk("done4_pulse", done4, 1'b0);
      if (done1 && lat1 < 0) begin lat1 = j; g1 = res1; gr1 = rdo1; end
      if (done4 && lat4 < 0) begin lat4 = j; g4 = res4; gr4 = rdo4; end
      if (lat1 >= 0 && lat4 >= 0) break;
    end
    e  = ref_md(f, x, y);
    e1 = is_fast(f, x, y) ? 1 : 33;
    e4 = is_fast(f, x, y) ? 1 : 9;
    chk($sformatf("lat1 op%0d", f), 64'(lat1), 64'(e1));
    chk($sformatf("lat4 op%0d", f), 64'(lat4), 64'(e4));
    chk($sformatf("busy1 op%0d", f), 64'(bc1), 64'(e1));
    chk($sformatf("busy4 op%0d", f), 64'(bc4), 64'(e4));
    chk($sformatf("res1 op%0d %h,%h", f, x, y), g1, e);
    chk($sformatf("res4 op%0d %h,%h", f, x, y), g4, e);
    chk("rd1", gr1, r);
    chk("rd4", gr4, r);
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] p1, p4;
    logic [4:0]  pr1, pr4;
    int d1, d4, t1, t2, l1;
    logic [31:0] s1, s4a, s4b;
    rst_n = 1'b0; start = 1'b0; kill1 = 1'b0; kill4 = 1'b0;
    op = '0; a = '0; b = '0; rd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst busy1", busy1, 0); chk("rst done1", done1, 0);
    chk("rst res1", res1, 0);   chk("rst rd1", rdo1, 0);
    chk("rst busy4", busy4, 0); chk("rst res4", res4, 0);
    rst_n = 1'b1;

    run_op(F3_MUL,    32'd7,          32'hFFFF_FFFD, 5'd5);
    run_op(F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6);
    run_op(F3_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7);
    run_op(F3_MULHSU, 32'hFFFF_FFFF,  32'h0000_0002, 5'd8);
    run_op(F3_DIV,    32'hFFFF_FFF9,  32'd2,         5'd9);
    run_op(F3_REM,    32'hFFFF_FFF9,  32'd2,         5'd10);
    run_op(F3_DIVU,   32'd100,        32'd7,         5'd11);
    run_op(F3_REMU,   32'd100,        32'd7,         5'd12);
    run_op(F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd13);
    run_op(F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd14);
    run_op(F3_DIVU,   32'd5,          32'd0,         5'd15);
    run_op(F3_REM,    32'd5,          32'd0,         5'd0);
    for (int i = 0; i < 30; i++)
      run_op(3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd(), 5'($urandom_range(0, 31)));

    // Kill mid-operation: no Done, outputs hold
    p1 = res1; p4 = res4; pr1 = rdo1; pr4 = rdo4; d1 = 0; d4 = 0;
    @(negedge clk);
    op = F3_DIV; a = 32'd1000; b = 32'd3; rd = 5'd9; start = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (done1) d1++;
      if (done4) d4++;
      if (j == 10) chk("kill busy1", busy1, 0);
      if (j == 4)  chk("kill busy4", busy4, 0);
      kill1 = (j == 9);
      kill4 = (j == 3);
    end
    chk("kill done1", 64'(d1), 0); chk("kill done4", 64'(d4), 0);
    chk("kill res1", res1, p1);    chk("kill res4", res4, p4);
    chk("kill rd1", rdo1, pr1);    chk("kill rd4", rdo4, pr4);

    // Start together with Kill launches nothing
    @(negedge clk);
    op = F3_MUL; a = 32'd3; b = 32'd4; start = 1'b1; kill1 = 1'b1; kill4 = 1'b1;
    @(negedge clk);
    start = 1'b0; kill1 = 1'b0; kill4 = 1'b0;
    chk("sk busy1", busy1, 0); chk("sk busy4", busy4, 0);
    d1 = 0; d4 = 0;
    repeat (40) begin @(negedge clk); if (done1) d1++; if (done4) d4++; end
    chk("sk done1", 64'(d1), 0); chk("sk done4", 64'(d4), 0);

    // Back-to-back on the fast unit; the slow unit ignores the second Start while busy
    t1 = -1; t2 = -1; l1 = -1; s1 = '0; s4a = '0; s4b = '0;
    @(negedge clk);
    op = F3_MUL; a = 32'd7; b = 32'hFFFF_FFFD; rd = 5'd3; start = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 60; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (done1 && l1 < 0) begin l1 = j; s1 = res1; end
      if (done4 && t1 >= 0 && t2 < 0) begin t2 = j; s4b = res4; end
      if (done4 && t1 < 0) begin
        t1 = j; s4a = res4;
        op = F3_DIVU; a = 32'd100; b = 32'd7; rd = 5'd4; start = 1'b1;
      end
      if (l1 >= 0 && t2 >= 0) break;
    end
    chk("b2b first lat4", 64'(t1), 9);
    chk("b2b first res4", s4a, 32'hFFFF_FFEB);
    chk("b2b second lat4", 64'(t2), 19);
    chk("b2b second res4", s4b, 32'd14);
    chk("b2b lat1", 64'(l1), 33);
    chk("b2b res1 held ops", s1, 32'hFFFF_FFEB);

    // Reset in the middle of CALC clears everything at the next edge
    @(negedge clk);
    op = F3_MUL; a = 32'd9; b = 32'd9; rd = 5'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre-rst busy1", busy1, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid-rst busy1", busy1, 0); chk("mid-rst res1", res1, 0);
    chk("mid-rst rd1", rdo1, 0);    chk("mid-rst busy4", busy4, 0);
    chk("mid-rst res4", res4, 0);   chk("mid-rst rd4", rdo4, 0);
    chk("mid-rst done1", done1, 0); chk("mid-rst done4", done4, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_muldiv_unit.md
Name: riscv_muldiv_unit

Overview:
- Parametrised iterative RV32M multiply/divide unit that sits alongside the ALU in the Execute stage of the pipelined core.
- Accepts one operation at a time from Execute and asserts Busy so the hazard unit stalls Fetch/Decode/Execute.
- Returns a registered result with its destination register tag, which feeds the Memory pipeline register.
- Generalises the single-cycle ALU path with a multi-cycle, configurable-throughput datapath and flush/kill support.

Parameters:
- WIDTH, 32, operand/result width; even, >= 8.
- BITS_PER_CYCLE, 1, quotient/multiplier bits retired per iteration; one of 1, 2, 4; must divide WIDTH.
- Derived constant N = WIDTH/BITS_PER_CYCLE, the iteration count.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- Start  input  1  launch request from Execute (M-extension instruction present)
- Kill  input  1  abort current or requested operation (branch flush, FlushE)
- Op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- SrcA  input  WIDTH  rs1 value after forwarding
- SrcB  input  WIDTH  rs2 value after forwarding
- RdIn  input  5  destination register tag
- Busy  output  1  operation in flight; stall request to hazard unit
- Done  output  1  single-cycle pulse; Result/RdOut valid
- Result  output  WIDTH  registered result
- RdOut  output  5  registered destination tag

Behaviour:
- Reset: reset is synchronous, active-low; clk is the single clock. When reset==0 at a rising edge:
  - state becomes IDLE.
  - Busy=0, Done=0, Result=0, RdOut=0.
  - Any operation in flight is discarded.
- States: IDLE, CALC, FIN. Busy = (state != IDLE), decoded combinationally from the state register.
- IDLE, Start=1, Kill=0 at edge k:
  - Latch Op and RdIn.
  - Latch |SrcA| and |SrcB| according to operand signedness (MULH: both signed; MULHSU: A signed; DIV/REM: both signed; others unsigned).
  - Latch the result-sign flags.
  - Clear the iteration counter and go to CALC.
- Fast path, decided at edge k instead of entering CALC:
  - Divide/remainder with SrcB==0: preload quotient = all ones, remainder = SrcA. Go to FIN.
  - Signed DIV/REM with SrcA = 1 followed by WIDTH-1 zeros and SrcB = all ones: preload quotient = SrcA, remainder = 0. Go to FIN.
- CALC: each edge retires BITS_PER_CYCLE bits.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring divide.
  - After N edges go to FIN.
  - The counter is log2(N)+1 bits wide and never wraps.
- FIN, one cycle:
  - Apply two's-complement sign correction.
  - Select the result: MUL takes the low WIDTH bits; MULH/MULHSU/MULHU take the high WIDTH bits; DIV/DIVU take the quotient; REM/REMU take the remainder. Remainder sign follows the dividend.
  - At the next edge register Result and RdOut, pulse Done=1 for exactly one cycle, and go to IDLE.
- Latency:
  - Normal path: Start sampled at edge k gives Busy high for N+1 cycles and Done high in the cycle after edge k+N+1, with Busy low in that cycle.
  - Fast path: Busy high for 1 cycle; Done after edge k+1.
- Back-to-back: Start=1 in the Done cycle is accepted; the next Done follows after the same latency.
- Start while Busy=1 is ignored; the held operands are not disturbed.
- Kill:
  - Kill=1 at any edge forces IDLE.
  - No Done is issued for the killed operation; Result and RdOut hold their previous values.
  - Kill and Start together: Kill wins and nothing launches.
- Result and RdOut hold their values between Done pulses.
- The unit never writes the register file itself. A Done with RdOut==0 is legal; the downstream x0 rule applies.

Decomposition:
- Shared package riscv_pkg holds:
  - M-extension funct3 constants (MUL..REMU).
  - OP opcode 0110011 and funct7 0000001.
  - The muldiv state enum (IDLE, CALC, FIN).
- One natural sub-module: muldiv_step, a combinational single-bit multiply/divide iteration. It is instantiated BITS_PER_CYCLE times in a generate chain inside CALC.

Test Plan:
- WIDTH=32, BPC=1: MUL, SrcA=7, SrcB=0xFFFFFFFD (-3) -> Done after 33 edges, Result=0xFFFFFFEB; Busy high exactly 33 cycles.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> Result=0xFFFFFFFE. MULH same operands -> 0x00000000. MULHSU 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 0x80000000 / 0xFFFFFFFF -> Result=0x80000000, Done one edge after start. DIVU 5/0 -> 0xFFFFFFFF. REM 5/0 -> 5.
- Start DIV, assert Kill at iteration 10 -> Busy drops next cycle, no Done, Result unchanged. Start in the same cycle as Kill -> not launched.
- BPC=4: MUL 7*-3 -> Done after 9 edges, same result. Back-to-back Start in the Done cycle -> second Done after 9 more edges. reset=0 mid-CALC -> all outputs 0 at the next edge.
